// File: rtl/algorithm_gcd_stein_if.sv
// Handshake bundle for the Stein GCD engine: operand request channel and result channel.
interface algorithm_gcd_stein_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out0;
   logic [CNT_W-1:0] out1;

   modport master (
      output in_valid, in0, in1, out_ready,
      input  in_ready, out_valid, out0, out1
   );

   modport slave (
      input  in_valid, in0, in1, out_ready,
      output in_ready, out_valid, out0, out1
   );
endinterface

// File: rtl/algorithm_gcd_stein.sv
// Binary (Stein) GCD engine: one shift/subtract step per clock, reports result and step count.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// REDUCE | strip common factors of two into k
// STEP   | odd/even shift or subtract until b reaches zero
// DONE   | result held on out0/out1 until out_ready
module algorithm_gcd_stein #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   algorithm_gcd_stein_if.slave  bus
);

   localparam int KW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      STEP   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [KW-1:0]    k_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] res_q;
   logic [CNT_W-1:0] cnt_out_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] cnt_d;

   // Step counter sticks at all-ones instead of wrapping.
   assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         k_q         <= '0;
         cnt_q       <= '0;
         res_q       <= '0;
         cnt_out_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.in0;
                  b_q        <= bus.in1;
                  k_q        <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  if (bus.in0 == '0 || bus.in1 == '0) begin
                     res_q       <= bus.in0 | bus.in1;
                     cnt_out_q   <= '0;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     state_q <= REDUCE;
                  end
               end
            end
            REDUCE: begin
               cnt_q <= cnt_d;
               if (!a_q[0] && !b_q[0]) begin
                  a_q <= a_q >> 1;
                  b_q <= b_q >> 1;
                  k_q <= k_q + KW'(1);
               end else begin
                  state_q <= STEP;
               end
            end
            STEP: begin
               if (b_q == '0) begin
                  // a holds the odd part of the gcd here, so the shift cannot exceed WIDTH bits.
                  res_q       <= a_q << k_q;
                  cnt_out_q   <= cnt_q;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_d;
                  if (!a_q[0]) begin
                     a_q <= a_q >> 1;
                  end else if (!b_q[0]) begin
                     b_q <= b_q >> 1;
                  end else if (a_q > b_q) begin
                     a_q <= a_q - b_q;
                  end else begin
                     b_q <= b_q - a_q;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out0      = res_q;
   assign bus.out1      = cnt_out_q;

endmodule
